param_prng: RTL and testbench

PARAM_PRNG -- requirements
Module: param_prng

---
 rtl/param_prng.sv | 109 ++++++++++
 tb/tb_param_prng.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_prng.sv
// param_prng: parameterised pseudo-random sample source with a one-entry output buffer.
//
// The generator is either a linear congruential generator (Mode=0) or a Galois LFSR
// (Mode=1). It advances one step whenever the output buffer is empty or the buffered
// sample is being consumed in the same cycle. The result goes to both the internal
// state and the registered Output.
//
// Optional feature: define PRNG_SAMPLE_COUNT_EN to count accepted samples on
// SampleCount. When it is undefined, SampleCount is tied to zero.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-high reset; overrides everything
//   Enable       in   permits the generator to advance
//   Mode         in   0 = LCG, 1 = Galois LFSR
//   SeedLoad     in   load Seed into the state and empty the buffer
//   Seed         in   seed value (WIDTH bits)
//   OutReady     in   consumer accepts Output this cycle
//   OutValid     out  Output holds an unconsumed sample
//   Output       out  current sample, registered (WIDTH bits)
//   SampleCount  out  number of accepted samples (32 bits)

module param_prng #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      LCG_MULT     = 5,
    parameter int unsigned      LCG_INC      = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Mode,
    input  logic             SeedLoad,
    input  logic [WIDTH-1:0] Seed,
    input  logic             OutReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] Output,
    output logic [31:0]      SampleCount
);

    typedef enum logic [0:0] {StEmpty, StFull} fsm_e;

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] out_q;

    logic             transfer;
    logic             step;
    logic [WIDTH-1:0] step_src;
    logic [WIDTH-1:0] lcg_next;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] gen_next;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        transfer = (fsm_q == StFull) && OutReady;
        step     = Enable && !SeedLoad && ((fsm_q == StEmpty) || transfer);

        // An all-zero LFSR state would lock up, so step from the default seed instead.
        step_src = (Mode && (state_q == '0)) ? SEED_DEFAULT : state_q;

        // Operands are WIDTH bits wide, so the product wraps mod 2^WIDTH.
        lcg_next  = step_src * WIDTH'(LCG_MULT) + WIDTH'(LCG_INC);
        lfsr_next = step_src[0] ? ((step_src >> 1) ^ LFSR_TAPS) : (step_src >> 1);
        gen_next  = Mode ? lfsr_next : lcg_next;

        load_val  = (Mode && (Seed == '0)) ? SEED_DEFAULT : Seed;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= SEED_DEFAULT;
            out_q   <= '0;
            fsm_q   <= StEmpty;
        end else if (SeedLoad) begin
            // A reseed drops any buffered sample; Output keeps its last value.
            state_q <= load_val;
            fsm_q   <= StEmpty;
        end else if (step) begin
            state_q <= gen_next;
            out_q   <= gen_next;
            fsm_q   <= StFull;
        end else if (transfer) begin
            fsm_q   <= StEmpty;
        end
    end

    assign OutValid = (fsm_q == StFull);
    assign Output   = out_q;

`ifdef PRNG_SAMPLE_COUNT_EN
    logic [31:0] count_q;

    // Every accepted sample is counted, including one taken in a reseed cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else if (transfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign SampleCount = count_q;
`else
    assign SampleCount = '0;
`endif

endmodule

// File: tb/tb_param_prng.sv
// Scoreboard bench for param_prng (default parameters, WIDTH=16).
// The driver applies stimulus on the falling edge and updates a reference model of
// the generator. Each cycle it queues the expected visible status. For every sample
// the model expects to be taken, it also queues that sample. A separate monitor pops
// and compares these entries whenever the DUT presents its outputs.

module tb_param_prng;

    localparam int unsigned W = 16;
`ifdef PRNG_SAMPLE_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Enable = 1'b0;
    logic          Mode = 1'b0;
    logic          SeedLoad = 1'b0;
    logic [W-1:0]  Seed = '0;
    logic          OutReady = 1'b0;
    logic          OutValid;
    logic [W-1:0]  Output;
    logic [31:0]   SampleCount;

    param_prng dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .Mode        (Mode),
        .SeedLoad    (SeedLoad),
        .Seed        (Seed),
        .OutReady    (OutReady),
        .OutValid    (OutValid),
        .Output      (Output),
        .SampleCount (SampleCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic         valid;
        logic [W-1:0] out;
        logic [31:0]  count;
    } status_t;

    status_t      status_q[$];
    logic [W-1:0] xfer_q[$];
    logic [W-1:0] seen[$];

    int checks = 0;
    int failures = 0;

    // Reference model: generator value, buffer occupancy, buffered sample, count.
    int unsigned m_state;
    bit          m_full;
    int unsigned m_out;
    logic [31:0] m_count;

    function automatic int unsigned lcg(input int unsigned s);
        return (s * 5 + 1) % 65536;
    endfunction

    function automatic int unsigned lfsr(input int unsigned s);
        if (s % 2 == 1) return (s / 2) ^ 32'hB400;
        return s / 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit md, input bit sl,
                              input int unsigned sd, input bit rdy);
        bit          xfer;
        int unsigned src;
        int unsigned nxt;
        xfer = m_full && rdy;
        if (rst) begin
            m_state = 1;
            m_out   = 0;
            m_full  = 0;
            m_count = 0;
        end else begin
            if (xfer && COUNT_EN) m_count = m_count + 1;
            if (sl) begin
                m_state = (md && sd == 0) ? 1 : sd;
                m_full  = 0;
            end else if (en && (!m_full || xfer)) begin
                src     = (md && m_state == 0) ? 1 : m_state;
                nxt     = md ? lfsr(src) : lcg(src);
                m_state = nxt;
                m_out   = nxt;
                m_full  = 1;
            end else if (xfer) begin
                m_full = 0;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit md, input bit sl,
                         input logic [W-1:0] sd, input bit rdy, input bit push = 1'b1);
        @(negedge Clock);
        Reset    = rst;
        Enable   = en;
        Mode     = md;
        SeedLoad = sl;
        Seed     = sd;
        OutReady = rdy;
        if (push) begin
            status_q.push_back('{valid: m_full, out: W'(m_out), count: m_count});
            if (m_full && rdy) xfer_q.push_back(W'(m_out));
        end
        model_step(rst, en, md, sl, int'(sd), rdy);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, Mode, 1'b0, '0, 1'b0);
    endtask

    task automatic check_seen(input string nm, input int n, input logic [W-1:0] e0,
                              input logic [W-1:0] e1, input logic [W-1:0] e2,
                              input logic [W-1:0] e3);
        logic [W-1:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++) begin
            chk($sformatf("%s_%0d", nm, i), 32'(seen[i]), 32'(e[i]));
        end
    endtask

    // Monitor: compares visible status every cycle and the sample on every transfer.
    initial begin
        status_t      st;
        logic [W-1:0] xe;
        forever begin
            @(negedge Clock);
            #1;
            if (status_q.size() > 0) begin
                st = status_q.pop_front();
                chk("out_valid", 32'(OutValid), 32'(st.valid));
                chk("output", 32'(Output), 32'(st.out));
                chk("sample_count", SampleCount, st.count);
            end
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                seen.push_back(Output);
                if (xfer_q.size() == 0) begin
                    chk("unexpected_transfer", 32'(Output), 32'hFFFF_FFFF);
                end else begin
                    xe = xfer_q.pop_front();
                    chk("transfer_sample", 32'(Output), 32'(xe));
                end
            end
        end
    end

    initial begin
        logic         md;
        logic [W-1:0] sd;
        m_state = 1; m_full = 0; m_out = 0; m_count = 0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
        #2;
        chk("reset_valid", 32'(OutValid), 32'd0);
        chk("reset_output", 32'(Output), 32'd0);
        chk("reset_count", SampleCount, 32'd0);

        // LCG stream from seed 0
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
        seen.delete();
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle();
        #2;
        check_seen("lcg_seq", 4, 16'd1, 16'd6, 16'd31, 16'd156);

        // LFSR stream from seed 1
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
        seen.delete();
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        idle();
        #2;
        check_seen("lfsr_seq", 3, 16'hB400, 16'h5A00, 16'h2D00, 16'h0000);

        // LFSR seed 0 substitutes the default seed
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
        seen.delete();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        idle();
        #2;
        check_seen("lfsr_zero_seed", 1, 16'hB400, 16'h0, 16'h0, 16'h0);

        // Backpressure hold, then drain with Enable low
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle();
        #2;
        chk("drain_valid", 32'(OutValid), 32'd0);

        // Reseed during a transfer, then reset mid-stream
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        #2;
        chk("midreset_valid", 32'(OutValid), 32'd1);
        idle();
        #2;
        chk("postreset_valid", 32'(OutValid), 32'd0);
        chk("postreset_output", 32'(Output), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
        #2;
        chk("postreset_state", 32'(Output), 32'd6);

        // Sample counter over 10 transfers
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (11) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle();
        #2;
        chk("count_10", SampleCount, COUNT_EN ? 32'd10 : 32'd0);

        // Randomised traffic
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) md = ~md;
            sd = ($urandom_range(3) == 0) ? '0 : W'($urandom_range(65535));
            cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), md,
                  ($urandom_range(15) == 0), sd, 1'($urandom_range(1)));
        end

        idle();
        idle();
        #2;
        chk("xfer_queue_drained", 32'(xfer_q.size()), 32'd0);
        chk("status_queue_drained", 32'(status_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
